// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - vending machine transaction controller (credit, timed windows, dispense/change)
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   coin_valid        single-cycle coin pulse, value selected by coin_code (1/2/5/10)
//   sel_valid         single-cycle selection pulse for item sel_item
//   cancel            single-cycle cancel pulse
//   time_end          elapsed seconds from the external timer
//   counting_sign     timer run enable; low for one cycle clears and restarts the timer
//   credit            credit currently held
//   dispense          high while the selected item is being dispensed
//   item_out          latched item index, valid while dispense is high
//   change_valid      single-cycle change/refund pulse, amount on change_out
//   change_out        amount returned, held until the next change pulse
//   coin_reject       single-cycle pulse: coin not accepted
//   no_credit         single-cycle pulse: selection with insufficient credit

module vend_controller #(
    parameter int unsigned TIMEOUT_S  = 10,
    parameter int unsigned DISPENSE_S = 3,
    parameter logic [7:0]  PRICE0     = 8'd15,
    parameter logic [7:0]  PRICE1     = 8'd20,
    parameter logic [7:0]  PRICE2     = 8'd25,
    parameter logic [7:0]  PRICE3     = 8'd40,
    parameter logic [7:0]  CREDIT_MAX = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       sel_valid,
    input  logic [1:0] sel_item,
    input  logic       cancel,
    input  logic [5:0] time_end,
    output logic       counting_sign,
    output logic [7:0] credit,
    output logic       dispense,
    output logic [1:0] item_out,
    output logic       change_valid,
    output logic [7:0] change_out,
    output logic       coin_reject,
    output logic       no_credit
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DISPENSE
    } state_t;

    localparam logic [5:0] TIMEOUT_T  = 6'(TIMEOUT_S);
    localparam logic [5:0] DISPENSE_T = 6'(DISPENSE_S);

    state_t     state;
    logic [7:0] coin_value;
    logic [7:0] price;
    logic [8:0] credit_sum;
    logic       timed_out;
    logic       hold_done;

    always_comb begin
        coin_value = 8'd1;
        case (coin_code)
            2'b00:   coin_value = 8'd1;
            2'b01:   coin_value = 8'd2;
            2'b10:   coin_value = 8'd5;
            default: coin_value = 8'd10;
        endcase
    end

    always_comb begin
        price = PRICE0;
        case (sel_item)
            2'd0:    price = PRICE0;
            2'd1:    price = PRICE1;
            2'd2:    price = PRICE2;
            default: price = PRICE3;
        endcase
    end

    // Nine bits so the overflow compare sees the true sum.
    assign credit_sum = {1'b0, credit} + {1'b0, coin_value};

    // time_end is only trusted while the timer is running; in the cycle
    // counting_sign is low it may still hold the previous window's count.
    assign timed_out = counting_sign && (time_end >= TIMEOUT_T);
    assign hold_done = counting_sign && (time_end >= DISPENSE_T);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            counting_sign <= 1'b0;
            credit        <= 8'd0;
            dispense      <= 1'b0;
            item_out      <= 2'd0;
            change_valid  <= 1'b0;
            change_out    <= 8'd0;
            coin_reject   <= 1'b0;
            no_credit     <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            coin_reject  <= 1'b0;
            no_credit    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    counting_sign <= 1'b0;
                    credit        <= 8'd0;
                    dispense      <= 1'b0;
                    // With zero credit every selection is insufficient.
                    no_credit     <= sel_valid;
                    if (coin_valid) begin
                        state         <= ST_COLLECT;
                        credit        <= coin_value;
                        // Timer was held clear through IDLE, so it can start directly.
                        counting_sign <= 1'b1;
                    end
                end

                ST_COLLECT: begin
                    counting_sign <= 1'b1;
                    if (timed_out || cancel) begin
                        change_valid  <= 1'b1;
                        change_out    <= credit;
                        credit        <= 8'd0;
                        counting_sign <= 1'b0;
                        coin_reject   <= coin_valid;
                        state         <= ST_IDLE;
                    end else if (sel_valid) begin
                        coin_reject <= coin_valid;
                        if (credit >= price) begin
                            item_out      <= sel_item;
                            credit        <= credit - price;
                            dispense      <= 1'b1;
                            counting_sign <= 1'b0;
                            state         <= ST_DISPENSE;
                        end else begin
                            no_credit <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (credit_sum <= {1'b0, CREDIT_MAX}) begin
                            credit        <= credit_sum[7:0];
                            counting_sign <= 1'b0;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                ST_DISPENSE: begin
                    counting_sign <= 1'b1;
                    coin_reject   <= coin_valid;
                    if (hold_done) begin
                        dispense      <= 1'b0;
                        counting_sign <= 1'b0;
                        credit        <= 8'd0;
                        state         <= ST_IDLE;
                        if (credit != 8'd0) begin
                            change_valid <= 1'b1;
                            change_out   <= credit;
                        end
                    end
                end

                default: begin
                    state         <= ST_IDLE;
                    counting_sign <= 1'b0;
                    dispense      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - self-checking bench for vend_controller with a fast timer and reference model

module tb_vend_controller;

    localparam int TICK_CYC   = 4;
    localparam int TIMEOUT_S  = 10;
    localparam int DISPENSE_S = 3;
    localparam int CREDIT_MAX = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_code = 2'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_item = 2'd0;
    logic       cancel = 1'b0;
    logic [5:0] time_end = 6'd0;
    logic       counting_sign;
    logic [7:0] credit;
    logic       dispense;
    logic [1:0] item_out;
    logic       change_valid;
    logic [7:0] change_out;
    logic       coin_reject;
    logic       no_credit;

    int checks = 0;
    int errors = 0;
    int tcnt = 0;

    vend_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel        (cancel),
        .time_end      (time_end),
        .counting_sign (counting_sign),
        .credit        (credit),
        .dispense      (dispense),
        .item_out      (item_out),
        .change_valid  (change_valid),
        .change_out    (change_out),
        .coin_reject   (coin_reject),
        .no_credit     (no_credit)
    );

    always #5 clk = ~clk;

    // Fast seconds timer: one "second" every TICK_CYC cycles, cleared while counting_sign is low.
    always @(posedge clk) begin
        if (!counting_sign) begin
            time_end <= 6'd0;
            tcnt     <= 0;
        end else if (tcnt == TICK_CYC - 1) begin
            tcnt     <= 0;
            time_end <= time_end + 6'd1;
        end else begin
            tcnt <= tcnt + 1;
        end
    end

    // Reference model: transaction view with window deadlines expressed in clock edges.
    int prices [4] = '{15, 20, 25, 40};
    int cyc = 0;
    int m_mode = 0;          // 0 idle, 1 collect, 2 dispense
    int m_credit = 0;
    int m_deadline = 0;
    int m_item = 0;
    int m_change_out = 0;
    bit m_change_valid = 0;
    bit m_coin_reject = 0;
    bit m_no_credit = 0;
    bit m_dispense = 0;
    bit m_cs = 0;

    function automatic int cval(input logic [1:0] c);
        case (c)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 5;
            default: return 10;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_credit = 0; m_item = 0; m_change_out = 0;
        m_change_valid = 0; m_coin_reject = 0; m_no_credit = 0;
        m_dispense = 0; m_cs = 0;
    endtask

    task automatic model_refund();
        m_change_valid = 1;
        m_change_out   = m_credit;
        m_credit       = 0;
    endtask

    // A window opened straight from IDLE sees time_end reach S after S*TICK_CYC edges;
    // a restarted window loses one extra edge to the clear cycle. The response follows one edge later.
    task automatic model_edge(input bit cv, input logic [1:0] cc, input bit sv, input logic [1:0] si, input bit ca);
        bit restart;
        restart = 0;
        cyc++;
        m_change_valid = 0; m_coin_reject = 0; m_no_credit = 0;
        case (m_mode)
            0: begin
                m_no_credit = sv;
                if (cv) begin
                    m_mode = 1;
                    m_credit = cval(cc);
                    m_deadline = cyc + TIMEOUT_S * TICK_CYC + 1;
                end
            end
            1: begin
                if (cyc >= m_deadline || ca) begin
                    model_refund();
                    m_mode = 0;
                    m_coin_reject = cv;
                end else if (sv) begin
                    m_coin_reject = cv;
                    if (m_credit >= prices[si]) begin
                        m_credit -= prices[si];
                        m_item = si;
                        m_mode = 2;
                        m_deadline = cyc + DISPENSE_S * TICK_CYC + 2;
                        restart = 1;
                    end else begin
                        m_no_credit = 1;
                    end
                end else if (cv) begin
                    if (m_credit + cval(cc) <= CREDIT_MAX) begin
                        m_credit += cval(cc);
                        m_deadline = cyc + TIMEOUT_S * TICK_CYC + 2;
                        restart = 1;
                    end else begin
                        m_coin_reject = 1;
                    end
                end
            end
            default: begin
                m_coin_reject = cv;
                if (cyc >= m_deadline) begin
                    if (m_credit > 0) model_refund();
                    m_credit = 0;
                    m_mode = 0;
                end
            end
        endcase
        m_dispense = (m_mode == 2);
        m_cs = (m_mode != 0) && !restart;
    endtask

    // Drive one cycle of inputs (called at a negedge), returns at the next negedge.
    task automatic tick(input bit cv, input logic [1:0] cc, input bit sv, input logic [1:0] si, input bit ca);
        coin_valid = cv; coin_code = cc; sel_valid = sv; sel_item = si; cancel = ca;
        @(posedge clk);
        model_edge(cv, cc, sv, si, ca);
        @(negedge clk);
        coin_valid = 0; sel_valid = 0; cancel = 0;
    endtask

    task automatic idle_tick();
        tick(0, 2'd0, 0, 2'd0, 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({counting_sign, credit, dispense, item_out, change_valid, change_out, coin_reject, no_credit} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {counting_sign, credit, dispense, item_out, change_valid, change_out, coin_reject, no_credit});
        end
        rst_n = 1'b1;
        idle_tick();
        checks++;
        if (counting_sign !== 1'b0 || credit !== 8'd0) begin
            errors++;
            $display("FAIL reset_idle: got cs=%0d credit=%0d expected cs=0 credit=0", counting_sign, credit);
        end
    endtask

    task automatic test_buy_change();
        int hi;
        tick(1, 2'd3, 0, 2'd0, 0);
        tick(1, 2'd3, 0, 2'd0, 0);
        tick(1, 2'd2, 0, 2'd0, 0);
        checks++;
        if (credit !== 8'd25) begin errors++; $display("FAIL buy_credit25: got %0d expected 25", credit); end
        tick(0, 2'd0, 1, 2'd0, 0);
        checks++;
        if (credit !== 8'd10 || dispense !== 1'b1 || item_out !== 2'd0 || counting_sign !== 1'b0) begin
            errors++;
            $display("FAIL buy_select: got credit=%0d disp=%0d item=%0d cs=%0d expected 10 1 0 0",
                     credit, dispense, item_out, counting_sign);
        end
        hi = 1;
        for (int i = 0; i < 200; i++) begin
            idle_tick();
            if (!dispense) break;
            hi++;
        end
        checks++;
        if (hi !== DISPENSE_S * TICK_CYC + 2) begin
            errors++; $display("FAIL buy_dispense_len: got %0d cycles expected %0d", hi, DISPENSE_S * TICK_CYC + 2);
        end
        checks++;
        if (change_valid !== 1'b1 || change_out !== 8'd10 || credit !== 8'd0 || counting_sign !== 1'b0) begin
            errors++;
            $display("FAIL buy_change: got cv=%0d out=%0d credit=%0d cs=%0d expected 1 10 0 0",
                     change_valid, change_out, credit, counting_sign);
        end
        idle_tick();
        checks++;
        if (change_valid !== 1'b0 || change_out !== 8'd10) begin
            errors++; $display("FAIL buy_change_width: got cv=%0d out=%0d expected 0 10", change_valid, change_out);
        end
    endtask

    task automatic test_no_credit();
        tick(1, 2'd2, 0, 2'd0, 0);
        tick(0, 2'd0, 1, 2'd3, 0);
        checks++;
        if (no_credit !== 1'b1 || credit !== 8'd5 || dispense !== 1'b0 || counting_sign !== 1'b1) begin
            errors++;
            $display("FAIL no_credit_pulse: got nc=%0d credit=%0d disp=%0d cs=%0d expected 1 5 0 1",
                     no_credit, credit, dispense, counting_sign);
        end
        idle_tick();
        checks++;
        if (no_credit !== 1'b0 || credit !== 8'd5) begin
            errors++; $display("FAIL no_credit_width: got nc=%0d credit=%0d expected 0 5", no_credit, credit);
        end
        tick(0, 2'd0, 0, 2'd0, 1);
        checks++;
        if (change_valid !== 1'b1 || change_out !== 8'd5 || credit !== 8'd0) begin
            errors++; $display("FAIL cancel_refund: got cv=%0d out=%0d credit=%0d expected 1 5 0", change_valid, change_out, credit);
        end
        idle_tick();
    endtask

    task automatic test_timeout();
        int k;
        tick(1, 2'd1, 0, 2'd0, 0);
        k = 0;
        for (int i = 0; i < 300; i++) begin
            idle_tick();
            k++;
            if (change_valid) break;
        end
        checks++;
        if (k !== TIMEOUT_S * TICK_CYC + 1 || change_out !== 8'd2 || credit !== 8'd0 || counting_sign !== 1'b0) begin
            errors++;
            $display("FAIL timeout_refund: got k=%0d out=%0d credit=%0d cs=%0d expected %0d 2 0 0",
                     k, change_out, credit, counting_sign, TIMEOUT_S * TICK_CYC + 1);
        end
        idle_tick();
    endtask

    task automatic test_timeout_restart();
        int k;
        bit seen;
        tick(1, 2'd1, 0, 2'd0, 0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (time_end == 6'd9) begin seen = 1; break; end
            idle_tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL restart_wait9: got time_end=%0d expected 9", time_end); end
        tick(1, 2'd0, 0, 2'd0, 0);
        checks++;
        if (counting_sign !== 1'b0 || credit !== 8'd3 || change_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_low: got cs=%0d credit=%0d cv=%0d expected 0 3 0", counting_sign, credit, change_valid);
        end
        idle_tick();
        checks++;
        if (counting_sign !== 1'b1) begin errors++; $display("FAIL restart_high: got cs=%0d expected 1", counting_sign); end
        k = 1;
        for (int i = 0; i < 300; i++) begin
            if (change_valid) break;
            idle_tick();
            k++;
        end
        checks++;
        if (k !== TIMEOUT_S * TICK_CYC + 2 || change_out !== 8'd3) begin
            errors++;
            $display("FAIL restart_refund: got k=%0d out=%0d expected %0d 3", k, change_out, TIMEOUT_S * TICK_CYC + 2);
        end
        idle_tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 19; i++) tick(1, 2'd3, 0, 2'd0, 0);
        tick(1, 2'd2, 0, 2'd0, 0);
        checks++;
        if (credit !== 8'd195) begin errors++; $display("FAIL ovf_credit195: got %0d expected 195", credit); end
        tick(1, 2'd3, 0, 2'd0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd195 || counting_sign !== 1'b1) begin
            errors++;
            $display("FAIL ovf_reject: got rej=%0d credit=%0d cs=%0d expected 1 195 1", coin_reject, credit, counting_sign);
        end
        tick(1, 2'd2, 0, 2'd0, 0);
        checks++;
        if (coin_reject !== 1'b0 || credit !== 8'd200) begin
            errors++; $display("FAIL ovf_exact_max: got rej=%0d credit=%0d expected 0 200", coin_reject, credit);
        end
        tick(1, 2'd0, 0, 2'd0, 0);
        checks++;
        if (coin_reject !== 1'b1 || credit !== 8'd200) begin
            errors++; $display("FAIL ovf_above_max: got rej=%0d credit=%0d expected 1 200", coin_reject, credit);
        end
        tick(0, 2'd0, 0, 2'd0, 1);
        checks++;
        if (change_valid !== 1'b1 || change_out !== 8'd200) begin
            errors++; $display("FAIL ovf_cancel: got cv=%0d out=%0d expected 1 200", change_valid, change_out);
        end
        idle_tick();
    endtask

    task automatic test_cancel_coin();
        tick(1, 2'd2, 0, 2'd0, 0);
        tick(1, 2'd1, 0, 2'd0, 0);
        tick(1, 2'd2, 0, 2'd0, 1);
        checks++;
        if (change_valid !== 1'b1 || change_out !== 8'd7 || coin_reject !== 1'b1 || credit !== 8'd0 || counting_sign !== 1'b0) begin
            errors++;
            $display("FAIL cancel_coin: got cv=%0d out=%0d rej=%0d credit=%0d cs=%0d expected 1 7 1 0 0",
                     change_valid, change_out, coin_reject, credit, counting_sign);
        end
        tick(0, 2'd0, 1, 2'd0, 0);
        checks++;
        if (no_credit !== 1'b1 || credit !== 8'd0) begin
            errors++; $display("FAIL cancel_coin_idle: got nc=%0d credit=%0d expected 1 0", no_credit, credit);
        end
        idle_tick();
    endtask

    task automatic test_reset_dispense();
        bit bad;
        tick(1, 2'd3, 0, 2'd0, 0);
        tick(1, 2'd3, 0, 2'd0, 0);
        tick(1, 2'd3, 0, 2'd0, 0);
        tick(0, 2'd0, 1, 2'd0, 0);
        tick(1, 2'd1, 0, 2'd0, 0);
        checks++;
        if (dispense !== 1'b1 || coin_reject !== 1'b1 || credit !== 8'd15) begin
            errors++;
            $display("FAIL disp_coin_reject: got disp=%0d rej=%0d credit=%0d expected 1 1 15", dispense, coin_reject, credit);
        end
        idle_tick();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dispense !== 1'b0 || credit !== 8'd0 || counting_sign !== 1'b0 || item_out !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got disp=%0d credit=%0d cs=%0d item=%0d expected 0 0 0 0",
                     dispense, credit, counting_sign, item_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            idle_tick();
            if (change_valid !== 1'b0 || dispense !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL reset_no_change: got a change or dispense after reset, expected none"); end
    endtask

    task automatic test_random();
        bit cv, sv, ca;
        int phase;
        for (int i = 0; i < 3000; i++) begin
            phase = (i / 250) % 3;
            case (phase)
                0: begin cv = ($urandom % 3) == 0;  sv = ($urandom % 12) == 0; ca = ($urandom % 80) == 0; end
                1: begin cv = ($urandom % 70) == 0; sv = ($urandom % 40) == 0; ca = 0; end
                default: begin cv = ($urandom % 2) == 0; sv = ($urandom % 90) == 0; ca = ($urandom % 200) == 0; end
            endcase
            tick(cv, 2'($urandom), sv, 2'($urandom), ca);
            checks += 8;
            if (credit !== 8'(m_credit)) begin errors++; $display("FAIL rnd_credit @%0d: got %0d expected %0d", i, credit, m_credit); end
            if (counting_sign !== m_cs) begin errors++; $display("FAIL rnd_cs @%0d: got %0d expected %0d", i, counting_sign, m_cs); end
            if (dispense !== m_dispense) begin errors++; $display("FAIL rnd_dispense @%0d: got %0d expected %0d", i, dispense, m_dispense); end
            if (item_out !== 2'(m_item)) begin errors++; $display("FAIL rnd_item @%0d: got %0d expected %0d", i, item_out, m_item); end
            if (change_valid !== m_change_valid) begin errors++; $display("FAIL rnd_change_valid @%0d: got %0d expected %0d", i, change_valid, m_change_valid); end
            if (change_out !== 8'(m_change_out)) begin errors++; $display("FAIL rnd_change_out @%0d: got %0d expected %0d", i, change_out, m_change_out); end
            if (coin_reject !== m_coin_reject) begin errors++; $display("FAIL rnd_coin_reject @%0d: got %0d expected %0d", i, coin_reject, m_coin_reject); end
            if (no_credit !== m_no_credit) begin errors++; $display("FAIL rnd_no_credit @%0d: got %0d expected %0d", i, no_credit, m_no_credit); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_buy_change();
        test_no_credit();
        test_timeout();
        test_timeout_restart();
        test_overflow();
        test_cancel_coin();
        test_reset_dispense();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Transaction controller of the vending machine. Accepts coin and selection pulses, maintains the customer credit, and runs two timed windows (inactivity timeout and dispense hold) by driving `counting_sign` into the seconds timer and reading back its `time_end` seconds count. Sits directly upstream of the timer and drives the dispense and change outputs.

## Interface
- `TIMEOUT_S`, 10: seconds of inactivity in COLLECT before an automatic refund.
- `DISPENSE_S`, 3: seconds `dispense` is held high.
- `PRICE0`..`PRICE3`, 15/20/25/40: item prices in credit units (8-bit each).
- `CREDIT_MAX`, 200: highest credit that may be held.
- `clk`  in  1  system clock (40 MHz; timer ticks `time_end` once per second).
- `rst_n`  in  1  asynchronous, active-low reset.
- `coin_valid`  in  1  single-cycle coin-inserted pulse.
- `coin_code`  in  2  coin value: 00=1, 01=2, 10=5, 11=10 units.
- `sel_valid`  in  1  single-cycle item-select pulse.
- `sel_item`  in  2  selected item index.
- `cancel`  in  1  single-cycle cancel pulse.
- `time_end`  in  6  elapsed seconds from the timer; the timer clears it at the first clock edge with `counting_sign` low.
- `counting_sign`  out  1  timer run enable.
- `credit`  out  8  current credit.
- `dispense`  out  1  high for the whole DISPENSE state.
- `item_out`  out  2  latched item, valid while `dispense` is high.
- `change_valid`  out  1  single-cycle change/refund pulse.
- `change_out`  out  8  amount returned, valid with `change_valid`.
- `coin_reject`  out  1  single-cycle pulse: coin not accepted and physically returned.
- `no_credit`  out  1  single-cycle pulse: selection with insufficient credit.

## Operation
- All outputs are registered. Reset (async, `rst_n`=0) forces IDLE and clears every output to 0, including `credit` and `counting_sign`.
- States: IDLE, COLLECT, DISPENSE. Encoding is free.
- IDLE: `credit`=0, `counting_sign`=0.
  - Coin → COLLECT with `credit`=coin value and `counting_sign`=1.
  - `sel_valid` → `no_credit` pulse.
  - `cancel` is ignored.
- COLLECT, events in priority order (one event per cycle):
  1. Timeout: `counting_sign`=1 and `time_end`≥TIMEOUT_S. Pulse `change_valid` with `change_out`=`credit`, clear `credit`, go to IDLE.
  2. `cancel`: same refund, go to IDLE.
  3. `sel_valid`:
     - If `credit`≥PRICE[sel_item]: latch `item_out`, set `credit` = `credit` − price, go to DISPENSE, and restart the timer.
     - Otherwise pulse `no_credit` and stay.
  4. Coin:
     - If `credit`+value ≤ CREDIT_MAX: add the value and restart the timer.
     - Otherwise pulse `coin_reject`; `credit` is unchanged.
  - A coin arriving in the same cycle as a higher-priority event is rejected (`coin_reject`=1). A `sel_valid` arriving with timeout or cancel is ignored.
- DISPENSE: `dispense`=1. When `counting_sign`=1 and `time_end`≥DISPENSE_S:
  - Drop `dispense` and go to IDLE.
  - If `credit`>0, pulse `change_valid` with `change_out`=`credit`, then clear `credit`.
  - Coins during DISPENSE are rejected; `sel_valid` and `cancel` are ignored.
- Timer restart: `counting_sign` is driven 0 for exactly one cycle, then 1 again. `time_end` is compared only in cycles where `counting_sign` is 1; a stale `time_end` is never used.
- Arithmetic:
  - Credit addition uses a 9-bit sum before the CREDIT_MAX compare.
  - Subtraction never underflows, because it is gated by the compare.
  - `change_out` holds its value until the next pulse.

## Timing
- Pulse latency: every response to an input pulse (state change, `credit` update, `change_valid`, `coin_reject`, `no_credit`) is visible the cycle after the input pulse.
- Restart sequence:
  - Cycle after the accepting edge: `counting_sign`=0.
  - Timer clears at the following edge.
  - `counting_sign` is 1 again from that edge on.
- Timeout edge: the timeout fires in the first cycle where `time_end` reaches TIMEOUT_S. The refund appears one cycle later.
- Dispense window: `dispense` is high from the selection response cycle until DISPENSE_S seconds plus the restart cycle, plus one cycle.
- `change_valid` never coincides with `coin_reject` for the same coin. Output pulses are exactly one cycle wide.
- Reset mid-DISPENSE or mid-COLLECT:
  - Outputs clear immediately.
  - No change pulse is issued; the credit is lost by design.
  - `counting_sign`=0 clears the timer at the next edge.

## Test plan
Benches may substitute a fast timer model, ticking `time_end` every N cycles.
- **Coin collect and buy with change:** coins 10, 10, 5 (credit 25), then select item 0 (price 15).
  - `credit`=10.
  - `dispense`=1 with `item_out`=0 for 3 s.
  - Then `change_valid` with `change_out`=10, and IDLE.
- **Insufficient credit:** coin 5, select item 3.
  - `no_credit` pulse.
  - `credit` stays 5.
  - Remains in COLLECT.
- **Inactivity timeout:** coin 2, then no input.
  - At `time_end`=10, `change_out`=2 refund, then IDLE.
  - A coin at `time_end`=9 restarts the window: one-cycle `counting_sign` low, and no refund at 10.
- **Overflow reject:** drive `credit` to 195, insert 10.
  - `coin_reject` pulse.
  - `credit` stays 195.
- **Simultaneous cancel and coin:** credit 7, then `cancel` and coin 5 in the same cycle.
  - `change_out`=7.
  - `coin_reject`=1.
  - IDLE with `credit`=0.
- **Async reset during DISPENSE:**
  - `dispense`, `credit`, and `counting_sign` all go to 0 without waiting for a clock edge.
  - No `change_valid`.
